// File: rtl/matrix_mac_sequencer.sv
// Sequencer that time-shares one multiply-accumulate PE to compute C = A x B for
// 2x2 matrices of 2-bit unsigned values; each output element is the sum of two PE terms.
module matrix_mac_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  mat_a,
    input  logic [7:0]  mat_b,
    output logic        pe_clr,
    output logic        pe_load,
    output logic [1:0]  pe_row,
    output logic [1:0]  pe_col,
    input  logic [5:0]  pe_result,
    input  logic        pe_done,
    output logic [23:0] mat_c,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [2:0]  dbg_state
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic          i_q, i_d, j_q, j_d, k_q, k_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0]    res_q, res_d;
    logic [23:0]   mat_c_q, mat_c_d;
    logic          busy_q, busy_d, done_q, done_d, terr_q, terr_d;
    logic          pe_clr_q, pe_clr_d, pe_load_q, pe_load_d;
    logic [1:0]    pe_row_q, pe_row_d, pe_col_q, pe_col_d;

    // Handshake: start is a request sampled only in IDLE (no ready is returned; busy
    // rises the cycle after acceptance); done is a single-cycle valid for mat_c/timeout_err.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        timer_d = timer_q;
        res_d   = res_q;
        mat_c_d = mat_c_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = mat_a;
                    b_d     = mat_b;
                    mat_c_d = '0;
                    terr_d  = 1'b0;
                    i_d     = 1'b0;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pe_done) begin
                    if (!k_q) begin
                        k_d     = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        res_d   = pe_result;
                        state_d = S_STORE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        terr_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_STORE: begin
                case ({i_q, j_q})
                    2'b00:   mat_c_d[5:0]   = res_q;
                    2'b01:   mat_c_d[11:6]  = res_q;
                    2'b10:   mat_c_d[17:12] = res_q;
                    default: mat_c_d[23:18] = res_q;
                endcase
                k_d = 1'b0;
                if (i_q && j_q) begin
                    state_d = S_DONE;
                end else begin
                    {i_d, j_d} = {i_q, j_q} + 2'd1;
                    state_d    = S_CLEAR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        pe_clr_d  = (state_d == S_CLEAR);
        pe_load_d = (state_d == S_LOAD);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d == S_CLEAR) || (state_d == S_LOAD) ||
                    (state_d == S_WAIT)  || (state_d == S_STORE);
        pe_row_d  = pe_row_q;
        pe_col_d  = pe_col_q;
        if (state_d == S_LOAD) begin
            pe_row_d = a_q[{i_d, k_d, 1'b0} +: 2];
            pe_col_d = b_q[{k_d, j_d, 1'b0} +: 2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= 1'b0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            timer_q   <= '0;
            res_q     <= '0;
            mat_c_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            pe_clr_q  <= 1'b0;
            pe_load_q <= 1'b0;
            pe_row_q  <= '0;
            pe_col_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            res_q     <= res_d;
            mat_c_q   <= mat_c_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            pe_clr_q  <= pe_clr_d;
            pe_load_q <= pe_load_d;
            pe_row_q  <= pe_row_d;
            pe_col_q  <= pe_col_d;
        end
    end

    // The PE is held in reset for as long as our own reset is asserted.
    assign pe_clr      = pe_clr_q | rst;
    assign pe_load     = pe_load_q;
    assign pe_row      = pe_row_q;
    assign pe_col      = pe_col_q;
    assign mat_c       = mat_c_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Bench for matrix_mac_sequencer: behavioural PE model, directed runs with
// hand-computed results, and a done-triggered scoreboard.
module tb_matrix_mac_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, pe_done;
    logic [7:0]  mat_a, mat_b;
    logic        pe_clr, pe_load, busy, done, timeout_err;
    logic [1:0]  pe_row, pe_col;
    logic [5:0]  pe_result;
    logic [23:0] mat_c;
    logic [2:0]  dbg_state;

    matrix_mac_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .mat_a(mat_a), .mat_b(mat_b),
        .pe_clr(pe_clr), .pe_load(pe_load), .pe_row(pe_row), .pe_col(pe_col),
        .pe_result(pe_result), .pe_done(pe_done), .mat_c(mat_c), .busy(busy),
        .done(done), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] c;
        logic        terr;
        logic [7:0]  lat;
        logic [3:0]  loads;
        logic [2:0]  clrs;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // PE model: clears on pe_clr, accumulates row*col on pe_load, raises pe_done on the
    // pe_d-th cycle after the load. stuck suppresses pe_done; spur injects it outside WAIT.
    int         pe_d = 3;
    bit         stuck = 0, spur = 0, active = 0;
    int         cnt = 0;
    logic [5:0] acc = '0;
    initial begin
        pe_done   = 1'b0;
        pe_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pe_clr) begin
                acc    = '0;
                active = 0;
            end
            if (pe_load) begin
                acc     = acc + pe_row * pe_col;
                cnt     = 0;
                active  = 1;
                pe_done = 1'b0;
            end else if (active) begin
                cnt++;
                pe_done = (cnt == pe_d) && !stuck;
                if (cnt == pe_d) active = 0;
            end else begin
                pe_done = 1'b0;
            end
            if (spur && (pe_clr || pe_load || !busy)) pe_done = 1'b1;
            pe_result = acc;
        end
    end

    // Monitor: measures latency and strobe counts per run, checks results on done.
    int cyc = 0, loads = 0, clrs = 0;
    bit busy_prev = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 0;
            end else begin
                if (busy && !busy_prev) begin
                    cyc   = 1;
                    loads = 0;
                    clrs  = 0;
                end else begin
                    cyc++;
                end
                loads += int'(pe_load);
                clrs  += int'(pe_clr);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mat_c", 32'(mat_c), 32'(e.c));
                        chk("timeout_err", 32'(timeout_err), 32'(e.terr));
                        chk("latency", 32'(cyc), 32'(e.lat));
                        chk("pe_load_count", 32'(loads), 32'(e.loads));
                        chk("pe_clr_count", 32'(clrs), 32'(e.clrs));
                        chk("busy_at_done", 32'(busy), 32'd0);
                    end
                end
                busy_prev = busy;
            end
        end
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        @(negedge clk);
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        mat_a = ~a;
        mat_b = ~b;
        chk("mat_c_zero_after_accept", 32'(mat_c), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("terr_clear_after_accept", 32'(timeout_err), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
        chk({tag, "_mat_c"}, 32'(mat_c), 32'd0);
        chk({tag, "_pe_load"}, 32'(pe_load), 32'd0);
        chk({tag, "_pe_row"}, 32'(pe_row), 32'd0);
        chk({tag, "_pe_col"}, 32'(pe_col), 32'd0);
        chk({tag, "_pe_clr"}, 32'(pe_clr), 32'd1);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        mat_a = '0;
        mat_b = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("pe_clr_after_reset", 32'(pe_clr), 32'd0);

        // Identity x B with D=3, spurious pe_done, a start pulse and input change mid-run.
        spur = 1;
        pe_d = 3;
        issue(8'h41, 8'hE4, '{c: 24'h0C2040, terr: 1'b0, lat: 8'd41, loads: 4'd8, clrs: 3'd4});
        repeat (5) @(negedge clk);
        start = 1'b1;
        mat_a = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);

        // Start held through the DONE cycle: accepted only once, in the following IDLE cycle.
        spur  = 0;
        pe_d  = 2;
        mat_a = 8'hFF;
        mat_b = 8'hFF;
        start = 1'b1;
        exp_q.push_back('{c: 24'h492492, terr: 1'b0, lat: 8'd33, loads: 4'd8, clrs: 3'd4});
        @(negedge clk);
        chk("busy_in_idle_after_done", 32'(busy), 32'd0);
        chk("mat_c_held_after_done", 32'(mat_c), 32'h0C2040);
        @(negedge clk);
        start = 1'b0;
        mat_a = 8'h00;
        mat_b = 8'h00;
        chk("mat_c_zero_second_run", 32'(mat_c), 32'd0);
        wait_done(100);
        @(negedge clk);

        // pe_done stuck low: abort after 15 WAIT cycles.
        stuck = 1;
        issue(8'h41, 8'hE4, '{c: 24'h000000, terr: 1'b1, lat: 8'd18, loads: 4'd1, clrs: 3'd1});
        wait_done(100);
        @(negedge clk);
        chk("terr_sticky_in_idle", 32'(timeout_err), 32'd1);
        stuck = 0;

        // General product with D=1; also confirms the timeout flag is cleared.
        pe_d = 1;
        issue(8'h1B, 8'h4E, '{c: 24'h0C22C6, terr: 1'b0, lat: 8'd25, loads: 4'd8, clrs: 3'd4});
        wait_done(100);
        @(negedge clk);

        // Reset in WAIT of the third element: no done pulse may follow.
        pe_d = 3;
        @(negedge clk);
        mat_a = 8'hFF;
        mat_b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (loads < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reached_third_element", 32'(loads >= 5), 32'd1);
        @(negedge clk);
        chk("in_wait_before_reset", 32'(dbg_state), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Normal run after the aborted one.
        issue(8'h41, 8'hE4, '{c: 24'h0C2040, terr: 1'b0, lat: 8'd41, loads: 4'd8, clrs: 3'd4});
        wait_done(100);
        repeat (3) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
